// File: rtl/knight_sprite_locator_pkg.sv
// Shared types and default sprite geometry for the knight locator.
// Optional macro: KNIGHT_MIRROR_EN (horizontal mirroring).
package knight_pkg;

  typedef enum logic [1:0] {
    STAND = 2'd0,
    WALK1 = 2'd1,
    WALK2 = 2'd2,
    WALK3 = 2'd3
  } anim_state_t;

  localparam int KNIGHT_W = 30;
  localparam int KNIGHT_H = 64;

endpackage

// File: rtl/knight_sprite_locator_if.sv
// Pixel/position inputs and sprite address outputs of the locator.
// Optional macro: KNIGHT_MIRROR_EN (horizontal mirroring).
interface knight_sprite_locator_if #(
  parameter int ADDR_W = 11
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic              frame_start;
  logic [9:0]        knight_x;
  logic [9:0]        knight_y;
  logic              walking;
  logic              facing_left;
  logic [ADDR_W-1:0] rom_address;
  logic              sprite_on;
  logic [1:0]        frame_idx;

  modport master (
    output DrawX, DrawY, blank, frame_start,
    output knight_x, knight_y, walking, facing_left,
    input  rom_address, sprite_on, frame_idx
  );

  modport slave (
    input  DrawX, DrawY, blank, frame_start,
    input  knight_x, knight_y, walking, facing_left,
    output rom_address, sprite_on, frame_idx
  );
endinterface

// File: rtl/knight_sprite_locator_anim_fsm.sv
// Walk-cycle animation state machine, advanced only on frame_start.
// Optional macro: KNIGHT_MIRROR_EN (unused here).
module knight_anim_fsm
  import knight_pkg::*;
#(
  parameter int TICKS_PER_FRAME = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_start_i,
  input  logic       walking_i,
  output logic [1:0] frame_idx_o
);

  localparam int CNT_W =
    (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TICKS_PER_FRAME - 1);

  anim_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and tick counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= STAND;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: hold between frame_start pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (frame_start_i) begin
      if (!walking_i) begin
        state_d = STAND;
        cnt_d   = '0;
      end else if (state_q == STAND) begin
        state_d = WALK1;
        cnt_d   = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        unique case (state_q)
          WALK1:   state_d = WALK2;
          WALK2:   state_d = WALK3;
          default: state_d = WALK1;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign frame_idx_o = state_q;

endmodule

// File: rtl/knight_sprite_locator.sv
// Per-pixel knight sprite box test and ROM addressing, 1-cycle latency.
// Optional macro: KNIGHT_MIRROR_EN (facing_left mirrors the column).
module knight_sprite_locator
  import knight_pkg::*;
#(
  parameter int SPR_W           = KNIGHT_W,
  parameter int SPR_H           = KNIGHT_H,
  parameter int ADDR_W          = 11,
  parameter int TICKS_PER_FRAME = 6
) (
  input logic                  vga_clk,
  input logic                  reset,
  knight_sprite_locator_if.slave bus
);

  logic [10:0]       x_i, y_i, kx_i, ky_i;
  logic [10:0]       dx, dy, col;
  logic              hit;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              on_d, on_q;

  assign x_i  = {1'b0, bus.DrawX};
  assign y_i  = {1'b0, bus.DrawY};
  assign kx_i = {1'b0, bus.knight_x};
  assign ky_i = {1'b0, bus.knight_y};

  assign hit = (x_i >= kx_i) && (x_i < kx_i + 11'(SPR_W)) &&
               (y_i >= ky_i) && (y_i < ky_i + 11'(SPR_H)) &&
               bus.blank;

  assign dx = x_i - kx_i;
  assign dy = y_i - ky_i;

`ifdef KNIGHT_MIRROR_EN
  assign col = bus.facing_left ? (11'(SPR_W - 1) - dx) : dx;
`else
  logic unused_facing_left;
  assign unused_facing_left = bus.facing_left;
  assign col = dx;
`endif

  // Address multiply-add, forced to zero outside the box
  always_comb begin
    addr_d = '0;
    on_d   = 1'b0;
    if (hit) begin
      addr_d = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(col);
      on_d   = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      addr_q <= '0;
      on_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      on_q   <= on_d;
    end
  end

  knight_anim_fsm #(
    .TICKS_PER_FRAME(TICKS_PER_FRAME)
  ) u_fsm (
    .clk_i         (vga_clk),
    .rst_i         (reset),
    .frame_start_i (bus.frame_start),
    .walking_i     (bus.walking),
    .frame_idx_o   (bus.frame_idx)
  );

  assign bus.rom_address = addr_q;
  assign bus.sprite_on   = on_q;

endmodule
